uart_rx_fifo: RTL

// Downstream of the UART receiver: captures each completed byte into a FIFO in the sysclk domain.

---
 rtl/uart_rx_fifo.sv | 97 +++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: synchronizes the busy flag, pushes rx_data on its
// falling edge, and exposes show-ahead read data, status flags and an interrupt to the CPU bus.
module uart_rx_fifo #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          rx_state,
  input  logic [7:0]    rx_data,
  input  logic          rd_en,
  input  logic          clr_ovf,
  input  logic          irq_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          irq
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             mem_q [DEPTH];

  logic s_sync;
  logic push;
  logic pop;
  logic push_acc;
  logic drop;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign push   = s_prev_q & ~s_sync;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;

  assign pop      = rd_en & ~empty;
  // A full FIFO still accepts a byte when a pop frees the head slot in the same cycle.
  assign push_acc = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx_state};
    s_prev_d   = s_sync;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);

    if (push_acc && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push_acc) count_d = count_q - (AW+1)'(1);

    // Set beats clear so an overrun coinciding with clr_ovf is never lost.
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      s_prev_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      s_prev_q   <= s_prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible between valid pointers.
  always_ff @(posedge sysclk) begin
    if (push_acc) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign overflow = overflow_q;
  assign irq      = irq_en & ~empty;

endmodule
